// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - request/response and ALU_TOP bus bundle for alu_req_arbiter
interface alu_req_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    // requester side
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [4*NUM_REQ-1:0]       req_fun;
    logic [A_WIDTH*NUM_REQ-1:0] req_a;
    logic [B_WIDTH*NUM_REQ-1:0] req_b;

    // drive to ALU_TOP
    logic [A_WIDTH-1:0]         A;
    logic [B_WIDTH-1:0]         B;
    logic [3:0]                 ALU_FUN;

    // results from ALU_TOP
    logic [OUT_WIDTH-1:0]       ARITHMETIC_OUT;
    logic [OUT_WIDTH-1:0]       Logic_OUT;
    logic [OUT_WIDTH-1:0]       CMP_OUT;
    logic [OUT_WIDTH-1:0]       SHIFT_OUT;
    logic                       Carry_OUT;
    logic                       ARITHMETIC_Flag;
    logic                       Logic_Flag;
    logic                       CMP_Flag;
    logic                       SHIFT_Flag;

    // response side
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic [OUT_WIDTH-1:0]       rsp_data;
    logic                       rsp_carry;
    logic                       busy;

    modport slave (
        input  req_valid, req_fun, req_a, req_b,
        output req_ready,
        output A, B, ALU_FUN,
        input  ARITHMETIC_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT,
        input  Carry_OUT, ARITHMETIC_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag,
        output rsp_valid, rsp_id, rsp_data, rsp_carry, busy,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_fun, req_a, req_b,
        input  req_ready,
        input  A, B, ALU_FUN,
        output ARITHMETIC_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT,
        output Carry_OUT, ARITHMETIC_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag,
        input  rsp_valid, rsp_id, rsp_data, rsp_carry, busy,
        output rsp_ready
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter sharing one ALU_TOP between requesters
module alu_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 32,
    parameter int ALU_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_req_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]   b_q, b_d;
    logic [3:0]           fun_q, fun_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_carry_q, rsp_carry_d;
    logic                 busy_q, busy_d;

    logic                 gnt_valid;
    logic [ID_W-1:0]      gnt_idx;
    logic [ID_W-1:0]      cand;
    logic [NUM_REQ-1:0]   req_ready;
    logic [3:0]           sel_fun;
    logic [A_WIDTH-1:0]   sel_a;
    logic [B_WIDTH-1:0]   sel_b;
    logic [OUT_WIDTH-1:0] alu_result;
    logic                 alu_carry;

    // Round-robin pick: scan from rr_ptr downwards in priority so the nearest valid wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cand == ID_W'(i) && bus.req_valid[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    // Grant strobe and payload of the winner; ready only while idle.
    always_comb begin
        req_ready = '0;
        sel_fun   = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_fun = bus.req_fun[4*i +: 4];
                sel_a   = bus.req_a[A_WIDTH*i +: A_WIDTH];
                sel_b   = bus.req_b[B_WIDTH*i +: B_WIDTH];
                if (state_q == IDLE && gnt_valid) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Result select by op class; carry only meaningful for arithmetic ops.
    always_comb begin
        alu_carry = 1'b0;
        case (fun_q[3:2])
            2'b00: begin
                alu_result = bus.ARITHMETIC_OUT;
                alu_carry  = bus.Carry_OUT;
            end
            2'b01:   alu_result = bus.Logic_OUT;
            2'b10:   alu_result = bus.CMP_OUT;
            default: alu_result = bus.SHIFT_OUT;
        endcase
    end

    // Next-state: accept in IDLE, count ALU_LAT settle edges plus one sample edge, then hold response.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    a_d      = sel_a;
                    b_d      = sel_b;
                    fun_d    = sel_fun;
                    rsp_id_d = gnt_idx;
                    rr_ptr_d = ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
                    cnt_d    = '0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == CNT_W'(ALU_LAT)) begin
                    rsp_data_d  = alu_result;
                    rsp_carry_d = alu_carry;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; async reset discards any op in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.ALU_FUN   = fun_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - scoreboard bench for alu_req_arbiter (ALU_LAT 1 and 3)
module tb_alu_req_arbiter;
    localparam int NR = 4;
    localparam int AW = 16;
    localparam int BW = 16;
    localparam int OW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_req_arbiter_if #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus0 ();
    alu_req_arbiter_if #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus1 ();

    alu_req_arbiter #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW), .ALU_LAT(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    alu_req_arbiter #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW), .ALU_LAT(3))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // ALU_TOP stand-in: each class gives a distinct, hand-computable result
    assign bus0.ARITHMETIC_OUT  = {16'h0, bus0.A} + {16'h0, bus0.B};
    assign bus0.Carry_OUT       = bus0.ARITHMETIC_OUT[16];
    assign bus0.Logic_OUT       = {16'h0, bus0.A ^ bus0.B};
    assign bus0.CMP_OUT         = {16'hC3C3, bus0.A & bus0.B};
    assign bus0.SHIFT_OUT       = {bus0.B, bus0.A};
    assign bus0.ARITHMETIC_Flag = 1'b0;
    assign bus0.Logic_Flag      = 1'b0;
    assign bus0.CMP_Flag        = 1'b0;
    assign bus0.SHIFT_Flag      = 1'b0;
    assign bus1.ARITHMETIC_OUT  = {16'h0, bus1.A} + {16'h0, bus1.B};
    assign bus1.Carry_OUT       = bus1.ARITHMETIC_OUT[16];
    assign bus1.Logic_OUT       = {16'h0, bus1.A ^ bus1.B};
    assign bus1.CMP_OUT         = {16'hC3C3, bus1.A & bus1.B};
    assign bus1.SHIFT_OUT       = {bus1.B, bus1.A};
    assign bus1.ARITHMETIC_Flag = 1'b0;
    assign bus1.Logic_Flag      = 1'b0;
    assign bus1.CMP_Flag        = 1'b0;
    assign bus1.SHIFT_Flag      = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc0     = 0;
    int acc1     = 0;
    int ngnt0    = 0;
    logic pv0    = 1'b0;
    logic pv1    = 1'b0;
    logic [34:0] q0[$];
    logic [34:0] q1[$];
    logic [3:0]  gq0[$];
    logic [3:0]  gq1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DUT0 monitor: grants, accept-to-valid latency, responses
    always @(negedge clk) begin
        if (rst) begin
            if (bus0.req_ready != 4'b0) begin
                if (gq0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL gnt0_unexpected: got req_ready %b expected none", bus0.req_ready);
                end else begin
                    check("gnt0", {60'h0, bus0.req_ready}, {60'h0, gq0.pop_front()});
                end
                acc0 = cyc;
                ngnt0++;
            end
            if (bus0.rsp_valid && !pv0) check("lat0", 64'(cyc - acc0), 64'd3);
            if (bus0.rsp_valid && bus0.rsp_ready) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rsp0_unexpected: got id %0d data %0h expected no response", bus0.rsp_id, bus0.rsp_data);
                end else begin
                    check("rsp0", {29'h0, bus0.rsp_id, bus0.rsp_data, bus0.rsp_carry}, {29'h0, q0.pop_front()});
                end
            end
            pv0 = bus0.rsp_valid;
        end else begin
            pv0 = 1'b0;
        end
    end

    // DUT1 monitor (ALU_LAT=3)
    always @(negedge clk) begin
        if (rst) begin
            if (bus1.req_ready != 4'b0) begin
                if (gq1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL gnt1_unexpected: got req_ready %b expected none", bus1.req_ready);
                end else begin
                    check("gnt1", {60'h0, bus1.req_ready}, {60'h0, gq1.pop_front()});
                end
                acc1 = cyc;
            end
            if (bus1.rsp_valid && !pv1) check("lat1", 64'(cyc - acc1), 64'd5);
            if (bus1.rsp_valid && bus1.rsp_ready) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rsp1_unexpected: got id %0d data %0h expected no response", bus1.rsp_id, bus1.rsp_data);
                end else begin
                    check("rsp1", {29'h0, bus1.rsp_id, bus1.rsp_data, bus1.rsp_carry}, {29'h0, q1.pop_front()});
                end
            end
            pv1 = bus1.rsp_valid;
        end else begin
            pv1 = 1'b0;
        end
    end

    task automatic start0(input int idx, input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b,
                          input bit want_rsp, input logic [31:0] data, input logic carry);
        logic [1:0] id;
        id = 2'(idx);
        bus0.req_fun[4*idx +: 4]  = fun;
        bus0.req_a[16*idx +: 16]  = a;
        bus0.req_b[16*idx +: 16]  = b;
        bus0.req_valid[idx]       = 1'b1;
        gq0.push_back(4'b0001 << idx);
        if (want_rsp) q0.push_back({id, data, carry});
    endtask

    task automatic wait_acc0(input int idx);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus0.req_ready[idx] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL acc0_timeout: req %0d not granted, got no grant in 100 cycles", idx);
        end
        @(posedge clk);
        #1;
        bus0.req_valid[idx] = 1'b0;
    endtask

    task automatic wait_drain0();
        int n;
        n = 0;
        while (q0.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL drain0_timeout: got %0d pending responses expected 0", q0.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        bus0.req_valid = '0; bus0.req_fun = '0; bus0.req_a = '0; bus0.req_b = '0; bus0.rsp_ready = 1'b1;
        bus1.req_valid = '0; bus1.req_fun = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("rst_busy",      {63'h0, bus0.busy},      64'h0);
        check("rst_rsp_valid", {63'h0, bus0.rsp_valid}, 64'h0);
        check("rst_A",         {48'h0, bus0.A},         64'h0);
        check("rst_B",         {48'h0, bus0.B},         64'h0);
        check("rst_ALU_FUN",   {60'h0, bus0.ALU_FUN},   64'h0);
        check("rst_rsp_id",    {62'h0, bus0.rsp_id},    64'h0);
        check("rst_rsp_data",  {32'h0, bus0.rsp_data},  64'h0);
        check("rst_req_ready", {60'h0, bus0.req_ready}, 64'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // all four valid from reset: grants 0,1,2,3,0
        start0(0, 4'b0000, 16'h0001, 16'h0002, 1'b1, 32'h0000_0003, 1'b0);
        start0(1, 4'b0100, 16'hF0F0, 16'h0FF0, 1'b1, 32'h0000_FF00, 1'b0);
        start0(2, 4'b1000, 16'h00FF, 16'h0F0F, 1'b1, 32'hC3C3_000F, 1'b0);
        start0(3, 4'b0001, 16'hFFFF, 16'h0002, 1'b1, 32'h0001_0001, 1'b1);
        gq0.push_back(4'b0001);
        q0.push_back({2'd0, 32'h0000_0003, 1'b0});
        n = 0;
        while (ngnt0 < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL rr_timeout: got %0d grants expected 5", ngnt0);
        end
        @(posedge clk);
        #1;
        bus0.req_valid = '0;
        wait_drain0();

        // single requester 2, add 5+7
        start0(2, 4'b0000, 16'd5, 16'd7, 1'b1, 32'd12, 1'b0);
        wait_acc0(2);
        wait_drain0();

        // backpressure: response held while rsp_ready low, new request not granted
        bus0.rsp_ready = 1'b0;
        start0(0, 4'b0000, 16'd3, 16'd4, 1'b1, 32'd7, 1'b0);
        wait_acc0(0);
        n = 0;
        while (!bus0.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        start0(1, 4'b0000, 16'd1, 16'd1, 1'b1, 32'd2, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", {63'h0, bus0.rsp_valid}, 64'h1);
            check("stall_id",    {62'h0, bus0.rsp_id},    64'h0);
            check("stall_data",  {32'h0, bus0.rsp_data},  64'd7);
            check("stall_ready", {60'h0, bus0.req_ready}, 64'h0);
        end
        @(posedge clk);
        #1;
        bus0.rsp_ready = 1'b1;
        wait_acc0(1);
        wait_drain0();

        // reset during EXEC: outputs clear at once, no stale response, rr_ptr back to 0
        start0(1, 4'b0000, 16'd10, 16'd20, 1'b0, 32'd0, 1'b0);
        wait_acc0(1);
        rst = 1'b0;
        #1;
        check("mid_busy",      {63'h0, bus0.busy},      64'h0);
        check("mid_rsp_valid", {63'h0, bus0.rsp_valid}, 64'h0);
        check("mid_A",         {48'h0, bus0.A},         64'h0);
        check("mid_B",         {48'h0, bus0.B},         64'h0);
        check("mid_ALU_FUN",   {60'h0, bus0.ALU_FUN},   64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_busy", {63'h0, bus0.busy}, 64'h0);
        start0(0, 4'b0100, 16'hAAAA, 16'h5555, 1'b1, 32'h0000_FFFF, 1'b0);
        start0(2, 4'b1100, 16'hFFFF, 16'h0001, 1'b1, 32'h0001_FFFF, 1'b0);
        wait_acc0(0);
        wait_acc0(2);
        wait_drain0();

        // ALU_LAT=3 instance: single op, response 4 edges after accept
        bus1.req_fun[7:4]   = 4'b0000;
        bus1.req_a[31:16]   = 16'd10;
        bus1.req_b[31:16]   = 16'd20;
        bus1.req_valid[1]   = 1'b1;
        gq1.push_back(4'b0010);
        q1.push_back({2'd1, 32'd30, 1'b0});
        n = 0;
        @(negedge clk);
        while (!bus1.req_ready[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus1.req_valid[1] = 1'b0;
        n = 0;
        while (q1.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL drain1_timeout: got %0d pending responses expected 0", q1.size());
        end

        repeat (4) @(posedge clk);
        if (gq0.size() != 0 || gq1.size() != 0) begin
            checks++; failures++;
            $display("FAIL grants_left: got %0d/%0d unserved grants expected 0", gq0.size(), gq1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test within 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule
